// File: rtl/cpu_pkg.sv
// Shared definitions for the unified memory port arbiter.
//   state_t         : arbiter FSM encoding (IDLE/ACCESS/WAIT/RESP, 2-bit)
//   owner_t         : which requester owns the current transaction
//   WORD_ALIGN_MASK : clears the byte-offset bits of a byte address
//   word_align()    : applies WORD_ALIGN_MASK
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_D  = 1'b1
  } owner_t;

  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & WORD_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle between the two requesters (fetch, data), the arbiter and the
// single-port word memory.
//   fetch side : if_req, if_addr -> ; <- if_ack, if_rdata
//   data side  : d_req, d_we, d_addr, d_wdata -> ; <- d_ack, d_rdata
//   memory side: <- mem_en, mem_we, mem_addr, mem_wdata ; mem_rdata ->
// Modports:
//   slave  : the arbiter's view (serves requesters, drives the memory)
//   master : the environment's view (requesters plus memory model)
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_ack;
  logic [31:0] d_rdata;

  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_ack, if_rdata, d_ack, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_ack, if_rdata, d_ack, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/arb_select.sv
// Combinational winner pick between fetch and data requests.
//   if_req, d_req : pending requests
//   starved       : fetch has lost STARVE_MAX arbitrations in a row
//   grant         : at least one request is pending
//   winner        : requester to serve; data wins unless fetch is starved
module arb_select
  import cpu_pkg::*;
(
  input  logic   if_req,
  input  logic   d_req,
  input  logic   starved,
  output logic   grant,
  output owner_t winner
);

  always_comb begin
    grant  = if_req | d_req;
    winner = OWN_IF;
    if (d_req && !(if_req && starved)) begin
      winner = OWN_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port word memory between instruction fetch
// (read-only) and the load/store stage. Level request / one-cycle ack
// handshake; data has priority, with a starvation guard for fetch.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous reset, active-low
//   bus   : mem_port_arbiter_if.slave (requester and memory signals)
//   busy  : high whenever the FSM is not in IDLE
// Parameters:
//   LAT        : memory read latency (mem_en cycle to mem_rdata valid), 1..15
//   STARVE_MAX : data wins over a pending fetch before fetch is forced, 1..15
module mem_port_arbiter
  import cpu_pkg::*;
#(
  parameter int unsigned LAT        = 1,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  mem_port_arbiter_if.slave    bus,
  output logic                 busy
);

  localparam logic [3:0] LAT_M1     = 4'(LAT - 1);
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  state_t      state_q, state_d;
  owner_t      owner_q, owner_d;
  logic        we_q, we_d;
  logic [3:0]  lat_q, lat_d;
  logic [3:0]  starve_q, starve_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        cap_if, cap_d;

  logic        mem_en_q, mem_we_q, if_ack_q, d_ack_q, busy_q;
  logic [31:0] if_rdata_q, d_rdata_q;

  logic        grant;
  owner_t      winner;

  arb_select u_arb_select (
    .if_req  (bus.if_req),
    .d_req   (bus.d_req),
    .starved (starve_q == STARVE_LIM),
    .grant   (grant),
    .winner  (winner)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    lat_d    = lat_q;
    starve_d = starve_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cap_if   = 1'b0;
    cap_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d = ACCESS;
          owner_d = winner;
          if (winner == OWN_D) begin
            we_d    = bus.d_we;
            addr_d  = word_align(bus.d_addr);
            wdata_d = bus.d_wdata;
            // Fetch lost this round; the counter saturates at the limit.
            if (bus.if_req && (starve_q < STARVE_LIM)) begin
              starve_d = starve_q + 4'd1;
            end
          end else begin
            we_d     = 1'b0;
            addr_d   = word_align(bus.if_addr);
            starve_d = 4'd0;
          end
        end
      end
      ACCESS: begin
        lat_d   = LAT_M1;
        state_d = WAIT;
      end
      WAIT: begin
        if (lat_q == 4'd0) begin
          // mem_rdata is valid in this cycle; stores leave rdata untouched.
          cap_if  = (owner_q == OWN_IF);
          cap_d   = (owner_q == OWN_D) && !we_q;
          state_d = RESP;
        end else begin
          lat_d = lat_q - 4'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered from next-state so no input reaches a port
  // combinationally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_q    <= OWN_IF;
      we_q       <= 1'b0;
      lat_q      <= 4'd0;
      starve_q   <= 4'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      mem_en_q   <= 1'b0;
      mem_we_q   <= 1'b0;
      if_ack_q   <= 1'b0;
      d_ack_q    <= 1'b0;
      busy_q     <= 1'b0;
      if_rdata_q <= 32'd0;
      d_rdata_q  <= 32'd0;
    end else begin
      owner_q    <= owner_d;
      we_q       <= we_d;
      lat_q      <= lat_d;
      starve_q   <= starve_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      mem_en_q   <= (state_d == ACCESS);
      mem_we_q   <= (state_d == ACCESS) && we_d;
      if_ack_q   <= (state_d == RESP) && (owner_d == OWN_IF);
      d_ack_q    <= (state_d == RESP) && (owner_d == OWN_D);
      busy_q     <= (state_d != IDLE);
      if (cap_if) begin
        if_rdata_q <= bus.mem_rdata;
      end
      if (cap_d) begin
        d_rdata_q <= bus.mem_rdata;
      end
    end
  end

  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_ack    = if_ack_q;
  assign bus.d_ack     = d_ack_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.d_rdata   = d_rdata_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: one instance with LAT=1, one with
// LAT=2 / STARVE_MAX=4, each backed by a small latency-accurate memory model.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy1, busy2;
  int   checks = 0;
  int   failures = 0;
  int   d1_acks = 0;
  int   if1_acks = 0;
  int   both2 = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if b1 ();
  mem_port_arbiter_if b2 ();

  mem_port_arbiter #(.LAT(1), .STARVE_MAX(4)) u_dut1 (
    .clk   (clk),
    .reset (rst_n),
    .bus   (b1),
    .busy  (busy1)
  );

  mem_port_arbiter #(.LAT(2), .STARVE_MAX(4)) u_dut2 (
    .clk   (clk),
    .reset (rst_n),
    .bus   (b2),
    .busy  (busy2)
  );

  // Memory for dut1: read-only, data valid exactly 1 cycle after mem_en.
  logic [31:0] rd1 = 32'hBAD0_BAD0;
  always @(posedge clk) begin
    if (b1.mem_en && !b1.mem_we)
      rd1 <= (b1.mem_addr == 32'h10) ? 32'hDEAD_BEEF : ~b1.mem_addr;
    else
      rd1 <= 32'hBAD0_BAD0;
  end
  assign b1.mem_rdata = rd1;

  // Memory for dut2: stores land in m2; data valid exactly 2 cycles after mem_en.
  logic [31:0] m2 [0:63];
  logic [63:0] wr2 = '0;
  logic [31:0] rd2a = 32'hBAD0_BAD0;
  logic [31:0] rd2b = 32'hBAD0_BAD0;
  always @(posedge clk) begin
    if (b2.mem_en && b2.mem_we) begin
      m2[b2.mem_addr[7:2]]  <= b2.mem_wdata;
      wr2[b2.mem_addr[7:2]] <= 1'b1;
    end
    if (b2.mem_en && !b2.mem_we)
      rd2a <= wr2[b2.mem_addr[7:2]] ? m2[b2.mem_addr[7:2]] : {16'h5A5A, b2.mem_addr[15:0]};
    else
      rd2a <= 32'hBAD0_BAD0;
    rd2b <= rd2a;
  end
  assign b2.mem_rdata = rd2b;

  always @(posedge clk) begin
    if (b1.d_ack) d1_acks <= d1_acks + 1;
    if (b1.if_ack) if1_acks <= if1_acks + 1;
    if (b2.d_ack && b2.if_ack) both2 <= both2 + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  initial begin
    b1.if_req = 0; b1.if_addr = 0; b1.d_req = 0; b1.d_we = 0; b1.d_addr = 0; b1.d_wdata = 0;
    b2.if_req = 0; b2.if_addr = 0; b2.d_req = 0; b2.d_we = 0; b2.d_addr = 0; b2.d_wdata = 0;

    // Reset state
    repeat (2) tick();
    chk("rst_mem_en", b1.mem_en, 0);
    chk("rst_if_ack", b1.if_ack, 0);
    chk("rst_d_ack", b2.d_ack, 0);
    chk("rst_busy", busy2, 0);
    chk("rst_mem_we", b2.mem_we, 0);
    chk("rst_mem_addr", b2.mem_addr, 0);
    chk("rst_if_rdata", b1.if_rdata, 0);
    chk("rst_d_rdata", b2.d_rdata, 0);
    rst_n = 1;
    tick();

    // Fetch only, LAT=1
    b1.if_addr = 32'h0000_0013; b1.if_req = 1;
    tick();
    chk("t1_mem_en", b1.mem_en, 1);
    chk("t1_mem_addr", b1.mem_addr, 32'h10);
    chk("t1_busy", busy1, 1);
    tick();
    chk("t1_ack_early", b1.if_ack, 0);
    tick();
    chk("t1_if_ack", b1.if_ack, 1);
    chk("t1_if_rdata", b1.if_rdata, 32'hDEAD_BEEF);
    b1.if_req = 0;
    tick();
    chk("t1_if_ack_low", b1.if_ack, 0);
    chk("t1_idle", busy1, 0);

    // Store then load, LAT=2
    b2.d_req = 1; b2.d_we = 1; b2.d_addr = 32'h41; b2.d_wdata = 32'hCAFE_F00D;
    tick();
    chk("t2_st_en", b2.mem_en, 1);
    chk("t2_st_we", b2.mem_we, 1);
    chk("t2_st_addr", b2.mem_addr, 32'h40);
    chk("t2_st_wdata", b2.mem_wdata, 32'hCAFE_F00D);
    tick();
    chk("t2_we_off", b2.mem_we, 0);
    chk("t2_en_off", b2.mem_en, 0);
    tick();
    chk("t2_ack_early", b2.d_ack, 0);
    tick();
    chk("t2_st_ack", b2.d_ack, 1);
    chk("t2_st_rdata", b2.d_rdata, 0);
    b2.d_we = 0; b2.d_addr = 32'h40;
    tick();
    chk("t2_gap_busy", busy2, 0);
    chk("t2_gap_ack", b2.d_ack, 0);
    tick();
    chk("t2_ld_en", b2.mem_en, 1);
    chk("t2_ld_we", b2.mem_we, 0);
    repeat (3) tick();
    chk("t2_ld_ack", b2.d_ack, 1);
    chk("t2_ld_rdata", b2.d_rdata, 32'hCAFE_F00D);

    // Starvation guard: d_req held; drop it after the 6th grant, fetch after the 7th
    b2.if_addr = 32'h100; b2.if_req = 1; b2.d_addr = 32'h80;
    for (int k = 0; k < 7; k++) begin
      bit win_if;
      win_if = (k == 4) || (k == 6);
      tick();
      tick();
      chk($sformatf("t3_grant_%0d", k), b2.mem_addr, win_if ? 32'h100 : 32'h80);
      repeat (3) tick();
      chk($sformatf("t3_if_ack_%0d", k), b2.if_ack, win_if ? 1 : 0);
      chk($sformatf("t3_d_ack_%0d", k), b2.d_ack, win_if ? 0 : 1);
      if (win_if) chk($sformatf("t3_if_rdata_%0d", k), b2.if_rdata, 32'h5A5A_0100);
      else chk($sformatf("t3_d_rdata_%0d", k), b2.d_rdata, 32'h5A5A_0080);
      if (k == 5) b2.d_req = 0;
      if (k == 6) b2.if_req = 0;
    end

    // Single contention: data first, fetch ack LAT+3 cycles after data ack
    tick();
    b2.if_addr = 32'h104; b2.d_addr = 32'h84; b2.if_req = 1; b2.d_req = 1;
    repeat (4) tick();
    chk("t4_d_ack", b2.d_ack, 1);
    chk("t4_if_wait", b2.if_ack, 0);
    chk("t4_d_rdata", b2.d_rdata, 32'h5A5A_0084);
    b2.d_req = 0;
    repeat (4) tick();
    chk("t4_if_early", b2.if_ack, 0);
    tick();
    chk("t4_if_ack", b2.if_ack, 1);
    chk("t4_if_rdata", b2.if_rdata, 32'h5A5A_0104);
    chk("t4_d_ack_low", b2.d_ack, 0);
    b2.if_req = 0;

    // Reset asserted in WAIT
    tick();
    b2.d_req = 1; b2.d_addr = 32'h40;
    tick();
    tick();
    rst_n = 0;
    #1;
    chk("t5_busy", busy2, 0);
    chk("t5_mem_en", b2.mem_en, 0);
    chk("t5_mem_addr", b2.mem_addr, 0);
    chk("t5_d_rdata", b2.d_rdata, 0);
    chk("t5_if_rdata", b2.if_rdata, 0);
    b2.d_req = 0;
    #2;
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("t5_no_ack_%0d", i), {b2.if_ack, b2.d_ack}, 0);
    end
    b2.if_addr = 32'h10; b2.if_req = 1;
    tick();
    chk("t5_next_en", b2.mem_en, 1);
    chk("t5_next_addr", b2.mem_addr, 32'h10);
    repeat (3) tick();
    chk("t5_next_ack", b2.if_ack, 1);
    chk("t5_next_rdata", b2.if_rdata, 32'h5A5A_0010);
    b2.if_req = 0;

    // Fetch request dropped after ACCESS still completes
    tick();
    b1.if_addr = 32'h20; b1.if_req = 1;
    tick();
    chk("t6_mem_en", b1.mem_en, 1);
    b1.if_req = 0;
    tick();
    chk("t6_ack_early", b1.if_ack, 0);
    tick();
    chk("t6_if_ack", b1.if_ack, 1);
    chk("t6_if_rdata", b1.if_rdata, 32'hFFFF_FFDF);
    tick();
    chk("t6_ack_once", b1.if_ack, 0);
    chk("t6_idle", busy1, 0);
    tick();
    chk("t6_still_idle", busy1, 0);
    chk("t6_no_reack", b1.if_ack, 0);

    chk("mon_dut1_d_acks", d1_acks, 0);
    chk("mon_dut1_if_acks", if1_acks, 2);
    chk("mon_dut2_both_acks", both2, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port, fixed-latency word memory between the IF stage (instruction fetch, read-only) and the MEM stage (load/store). It replaces the separate instruction and data memories with one unified backing store. Requesters use a level-request / single-cycle-ack handshake, and the pipeline stalls on req & ~ack. Data accesses have priority; a starvation guard bounds fetch latency.

Parameters:
LAT, 1, memory read latency in cycles from the mem_en cycle to the cycle mem_rdata is valid; legal range 1..15.
STARVE_MAX, 4, consecutive data wins over a pending fetch before fetch is forced to win; legal range 1..15.

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous reset, active-low: asserted when 0
if_req  in  1  fetch request, level, held until if_ack
if_addr  in  32  fetch byte address; bits [1:0] ignored
if_ack  out  1  one-cycle pulse: fetch complete, if_rdata valid
if_rdata  out  32  fetched word, registered, holds until next fetch ack
d_req  in  1  data request, level, held until d_ack
d_we  in  1  1 = store, 0 = load; sampled with d_req
d_addr  in  32  data byte address; bits [1:0] ignored
d_wdata  in  32  store data
d_ack  out  1  one-cycle pulse: data access complete
d_rdata  out  32  load word, registered; unchanged by stores
mem_en  out  1  one-cycle memory access strobe
mem_we  out  1  write enable, qualified by mem_en
mem_addr  out  32  {addr[31:2],2'b00}, stable from mem_en until ack
mem_wdata  out  32  write data, stable with mem_addr
mem_rdata  in  32  read data, valid exactly LAT cycles after the mem_en cycle
busy  out  1  1 in any state other than IDLE

Behaviour:
- Reset (reset=0, async): state IDLE; if_ack, d_ack, mem_en, mem_we, busy = 0; mem_addr, mem_wdata, if_rdata, d_rdata = 0; owner = IF; lat_cnt = 0; starve_cnt = 0.
- States: IDLE, ACCESS, WAIT, RESP.
- IDLE: no request, stay. Otherwise choose a winner, latch owner, address, we and wdata, and go to ACCESS.
- Winner selection: d_req only wins DATA. if_req only wins IF. If both are asserted and starve_cnt == STARVE_MAX, IF wins; otherwise DATA wins.
- starve_cnt: increments when DATA wins while if_req=1; clears when IF is granted; saturates at STARVE_MAX.
- ACCESS, 1 cycle: mem_en = 1, mem_we = latched we. Load lat_cnt = LAT-1, then go to WAIT.
- WAIT: lat_cnt decrements each cycle. When lat_cnt == 0, capture mem_rdata into the owner's rdata register (loads and fetches only) and go to RESP.
- RESP, 1 cycle: owner's ack = 1, then go to IDLE.
- Latency: request seen in IDLE at cycle T gives mem_en at T+1 and ack at T+LAT+2. Back-to-back accesses restart arbitration at T+LAT+3. Throughput is one access per LAT+3 cycles.
- Loser handling: the loser's req stays high with ack low and is served on a later IDLE. Both acks are never high in the same cycle.
- Req dropped mid-transaction (protocol violation): the transaction completes and the ack still pulses; no abort.
- Store: d_ack pulses, d_rdata keeps its previous value, and mem_rdata is ignored.
- Reset mid-transaction: immediate return to reset values. The in-flight response is discarded and no ack is issued.
- Outputs mem_*, acks and rdata are registered; no combinational path from inputs to outputs.

Decomposition:
- Shared package cpu_pkg: state encoding (IDLE/ACCESS/WAIT/RESP, 2-bit), owner encoding (OWN_IF=0, OWN_D=1), WORD_ALIGN_MASK constant.
- One sub-module, arb_select: combinational winner pick from if_req, d_req and starve_cnt == STARVE_MAX. The starvation counter stays in the top-level module.

Test Plan:
- Fetch only, LAT=1: if_req=1 at cycle 0 with if_addr=0x0000_0013, mem model returns 0xDEADBEEF -> mem_addr=0x10 and mem_en at cycle 1, if_ack with if_rdata=0xDEADBEEF at cycle 3, d_ack never high.
- Store then load, LAT=2: store 0xCAFEF00D to 0x40, then load 0x40 -> mem_we=1 only on the store strobe, d_ack at cycle 4 (store, d_rdata unchanged), then d_rdata=0xCAFEF00D on the load ack.
- Simultaneous requests, STARVE_MAX=4, d_req held continuously: data granted 4 times, then IF granted on the 5th arbitration, then starve_cnt=0 and data wins again.
- Single contention: if_req and d_req rise together -> data serviced first; if_ack follows LAT+3 cycles after d_ack.
- reset=0 asserted in WAIT -> all outputs 0 within the reset cycle, no ack after release, and the next request is served with normal latency.
- Protocol violation: if_req dropped after ACCESS -> if_ack still pulses once, then busy=0.
